iob_mem_responder: RTL and testbench

IOb native-bus responder (subordinate end of the bus driven by the CPU wrapper's instruction/data ports). Accepts `avalid`/`address`/`wdata`/`wstrb` requests, inserts configurable wait states on `ready`, and serves them from an internal byte-enabled single-port memory. Reads return `rvalid`/`rdata` one cycle after acceptance. Writes are silent; the initiator derives its own write ack. Used as boot/scratch memory and as a bus-model target in CPU system benches.

---
 rtl/iob_mem_responder_pkg.sv | 22 ++
 rtl/iob_mem_responder_if.sv | 24 ++
 rtl/iob_ram_sp_be.sv | 40 ++++
 rtl/iob_reg.sv | 18 +
 rtl/iob_mem_responder.sv | 127 ++++++++++++
 tb/tb_iob_mem_responder.sv | 232 +++++++++++++++++++++++
 6 files changed

// File: rtl/iob_mem_responder_pkg.sv
// Shared types and constants for the IOb memory responder: FSM encoding,
// address-offset helper and the random-stall LFSR constants.
package iob_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACC  = 2'd2
    } state_t;

    // Wide enough for WAIT_CYCLES (0..15) plus up to 3 random stall cycles.
    localparam int CNT_W = 5;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 as a mask over lfsr[7:0].
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic int addr_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/iob_mem_responder_if.sv
// IOb native bus: request (avalid/addr/wdata/wstrb), acceptance (ready)
// and read response (rvalid/rdata).
interface iob_mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                avalid;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                ready;
    logic                rvalid;
    logic [DATA_W-1:0]   rdata;

    modport master (
        output avalid, addr, wdata, wstrb,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  avalid, addr, wdata, wstrb,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/iob_ram_sp_be.sv
// Single-port RAM with per-byte write enables and a registered read port.
// Array contents are never reset; only the read-data register is.
module iob_ram_sp_be #(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  cke_i,
    input  logic                  en_i,
    input  logic [DATA_W/8-1:0]   we_i,
    input  logic [MEM_ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0]     d_i,
    output logic [DATA_W-1:0]     d_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [2**MEM_ADDR_W];
    logic              rd_en;

    assign rd_en = cke_i & en_i & ~|we_i;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (cke_i && en_i && we_i[b])
                mem[addr_i][b*8 +: 8] <= d_i[b*8 +: 8];
        end
    end

    // Output holds the last read word until the next read.
    iob_reg #(.DATA_W(DATA_W), .RST_VAL('0)) u_rdata (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (rd_en),
        .data_i (mem[addr_i]),
        .data_o (d_o)
    );

endmodule

// File: rtl/iob_reg.sv
// Generic register with asynchronous active-high reset and clock enable.
module iob_reg #(
    parameter int                 DATA_W  = 1,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)     data_o <= RST_VAL;
        else if (cke_i) data_o <= data_i;
    end

endmodule

// File: rtl/iob_mem_responder.sv
// IOb responder with configurable wait states backed by a byte-enabled RAM.
// Optional random stall insertion: define IOB_MEM_RESP_RAND_STALL_EN.
module iob_mem_responder
    import iob_mem_responder_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_ADDR_W  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    iob_mem_responder_if.slave  iob
);

    localparam int ALSB = addr_lsb(DATA_W);

    state_t           state, state_nxt;
    logic [1:0]       state_q;
    logic [CNT_W-1:0] wait_cnt, cnt_nxt;
    logic [CNT_W-1:0] extra, total;
    logic             ready, accept, is_wr, rd_acc;
    logic             unused_addr;

`ifdef IOB_MEM_RESP_RAND_STALL_EN
    logic [7:0] lfsr;

    iob_reg #(.DATA_W(8), .RST_VAL(LFSR_SEED)) u_lfsr (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .data_i ({lfsr[6:0], ^(lfsr & LFSR_TAPS)}),
        .data_o (lfsr)
    );

    assign extra = {{(CNT_W-2){1'b0}}, lfsr[1:0]};
`else
    assign extra = '0;
`endif

    assign total = CNT_W'(WAIT_CYCLES) + extra;
    assign state = state_t'(state_q);

    // wait_cnt counts the WAIT cycles still owed; ACC follows the last one,
    // so the request is accepted exactly `total` cycles after avalid rises.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                if (total == '0) begin
                    ready = 1'b1;
                end else if (iob.avalid) begin
                    if (total == CNT_W'(1)) begin
                        state_nxt = ACC;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = total - CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (!iob.avalid) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (wait_cnt <= CNT_W'(1)) begin
                    state_nxt = ACC;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = wait_cnt - CNT_W'(1);
                end
            end
            ACC: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    iob_reg #(.DATA_W(2), .RST_VAL(2'(IDLE))) u_state (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .data_i (state_nxt),
        .data_o (state_q)
    );

    iob_reg #(.DATA_W(CNT_W), .RST_VAL('0)) u_wait_cnt (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .data_i (cnt_nxt),
        .data_o (wait_cnt)
    );

    // Gated by cke so a held clock never advertises an acceptance it can't make.
    assign iob.ready = ready & cke_i;
    assign accept    = iob.avalid & iob.ready;
    assign is_wr     = |iob.wstrb;
    assign rd_acc    = accept & ~is_wr;

    iob_reg #(.DATA_W(1), .RST_VAL(1'b0)) u_rvalid (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .data_i (rd_acc),
        .data_o (iob.rvalid)
    );

    iob_ram_sp_be #(.DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W)) u_ram (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .en_i   (accept),
        .we_i   (iob.wstrb),
        .addr_i (iob.addr[MEM_ADDR_W+ALSB-1:ALSB]),
        .d_i    (iob.wdata),
        .d_o    (iob.rdata)
    );

    // Address bits outside the word index alias by design.
    assign unused_addr = ^iob.addr;

endmodule

// File: tb/tb_iob_mem_responder.sv
// Scoreboard bench: a zero-wait and a 3-wait responder share the request
// bus; expected read data is queued at issue and checked on rvalid.
module tb_iob_mem_responder;

    logic        clk = 1'b0, rst = 1'b0, cke = 1'b1;
    logic        av0 = 1'b0, av3 = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    int          tests = 0, fails = 0;
    logic [31:0] q0[$], q3[$];
    logic [31:0] e0, e3;

    iob_mem_responder_if #(.DATA_W(32), .ADDR_W(32)) i0 ();
    iob_mem_responder_if #(.DATA_W(32), .ADDR_W(32)) i3 ();

    assign i0.avalid = av0;
    assign i0.addr   = addr;
    assign i0.wdata  = wdata;
    assign i0.wstrb  = wstrb;
    assign i3.avalid = av3;
    assign i3.addr   = addr;
    assign i3.wdata  = wdata;
    assign i3.wstrb  = wstrb;

    iob_mem_responder #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .arst_i(rst), .cke_i(cke), .iob(i0)
    );
    iob_mem_responder #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .arst_i(rst), .cke_i(cke), .iob(i3)
    );

    always #5 clk = ~clk;

    // Scoreboard pop on every read response.
    always @(negedge clk) begin
        if (!rst && i0.rvalid) begin
            tests++;
            if (q0.size() == 0) begin
                fails++;
                $display("FAIL sb0_unexpected: rvalid=1 with no read outstanding");
            end else begin
                e0 = q0.pop_front();
                if (i0.rdata !== e0) begin
                    fails++;
                    $display("FAIL sb0_rdata: got %h want %h", i0.rdata, e0);
                end
            end
        end
        if (!rst && i3.rvalid) begin
            tests++;
            if (q3.size() == 0) begin
                fails++;
                $display("FAIL sb3_unexpected: rvalid=1 with no read outstanding");
            end else begin
                e3 = q3.pop_front();
                if (i3.rdata !== e3) begin
                    fails++;
                    $display("FAIL sb3_rdata: got %h want %h", i3.rdata, e3);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Entered just after a negedge; returns at the negedge after acceptance
    // with avalid still high so the caller can chain or drop it.
    task automatic do_req(input bit s3, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] st, input int lat, input logic [31:0] exp_rd,
                          input string nm);
        logic r, rv;
        addr = a; wdata = d; wstrb = st;
        if (s3) av3 = 1'b1; else av0 = 1'b1;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            r = s3 ? i3.ready : i0.ready;
            tests++;
            if (r !== (k == lat)) begin
                fails++;
                $display("FAIL %s_ready: cycle %0d ready=%b want %b", nm, k, r, (k == lat));
            end
        end
        if (st == 4'h0) begin
            if (s3) q3.push_back(exp_rd); else q0.push_back(exp_rd);
        end
        @(negedge clk);
        rv = s3 ? i3.rvalid : i0.rvalid;
        tests++;
        if (rv !== (st == 4'h0)) begin
            fails++;
            $display("FAIL %s_rvalid: rvalid=%b want %b", nm, rv, (st == 4'h0));
        end
    endtask

    task automatic idle(input int n);
        av0 = 1'b0; av3 = 1'b0; wstrb = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        tests += 6;
        if (i0.ready  !== 1'b1) begin fails++; $display("FAIL rst_ready0: got %b want 1", i0.ready); end
        if (i3.ready  !== 1'b0) begin fails++; $display("FAIL rst_ready3: got %b want 0", i3.ready); end
        if (i0.rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid0: got %b want 0", i0.rvalid); end
        if (i3.rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid3: got %b want 0", i3.rvalid); end
        if (i0.rdata  !== 32'h0) begin fails++; $display("FAIL rst_rdata0: got %h want 0", i0.rdata); end
        if (i3.rdata  !== 32'h0) begin fails++; $display("FAIL rst_rdata3: got %h want 0", i3.rdata); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        do_req(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, "wr0");
        do_req(0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, "rd0");
        idle(2);
    endtask

    task automatic test_strobes();
        do_req(0, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 32'h0, "strb_fill");
        do_req(0, 32'h20, 32'h11223344, 4'b0101, 0, 32'h0, "strb_wr");
        do_req(0, 32'h20, 32'h0, 4'h0, 0, 32'hFF22FF44, "strb_rd");
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = $urandom;
            do_req(0, 32'h200 + 32'(i*4), v[i], 4'hF, 0, 32'h0, "b2b_wr");
        end
        // Partial overwrite of word 2: only the top byte changes.
        do_req(0, 32'h208, 32'hAB00_0000, 4'b1000, 0, 32'h0, "b2b_part");
        v[2] = {8'hAB, v[2][23:0]};
        for (int i = 0; i < 4; i++)
            do_req(0, 32'h200 + 32'(i*4), 32'h0, 4'h0, 0, v[i], "b2b_rd");
        idle(2);
    endtask

    task automatic test_alias();
        do_req(0, 32'h0000_0004, 32'hA5A5A5A5, 4'hF, 0, 32'h0, "alias_wr");
        do_req(0, 32'h0000_1004, 32'h0, 4'h0, 0, 32'hA5A5A5A5, "alias_rd");
        idle(2);
    endtask

    task automatic test_wait3();
        do_req(1, 32'h40, 32'h12345678, 4'hF, 3, 32'h0, "w3_wr");
        idle(1);
        do_req(1, 32'h40, 32'h0, 4'h0, 3, 32'h12345678, "w3_rd");
        idle(2);
    endtask

    task automatic test_abort();
        // Drop avalid during WAIT.
        addr = 32'h40; wdata = 32'hCAFEF00D; wstrb = 4'hF; av3 = 1'b1;
        #1;
        tests++;
        if (i3.ready !== 1'b0) begin fails++; $display("FAIL abort_w_ready0: got %b want 0", i3.ready); end
        @(negedge clk);
        av3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++;
            if (i3.ready !== 1'b0 || i3.rvalid !== 1'b0) begin
                fails++;
                $display("FAIL abort_w_idle: ready=%b rvalid=%b want 0 0", i3.ready, i3.rvalid);
            end
            @(negedge clk);
        end
        // Drop avalid in the ACC cycle itself.
        wdata = 32'hBAD0BAD0; av3 = 1'b1;
        repeat (3) @(negedge clk);
        av3 = 1'b0;
        #1;
        tests++;
        if (i3.ready !== 1'b1) begin fails++; $display("FAIL abort_acc_ready: got %b want 1", i3.ready); end
        @(negedge clk);
        #1;
        tests++;
        if (i3.ready !== 1'b0 || i3.rvalid !== 1'b0) begin
            fails++;
            $display("FAIL abort_acc_after: ready=%b rvalid=%b want 0 0", i3.ready, i3.rvalid);
        end
        @(negedge clk);
        do_req(1, 32'h40, 32'h0, 4'h0, 3, 32'h12345678, "abort_rd");
        idle(2);
    endtask

    task automatic test_reset_mid_wait();
        addr = 32'h40; wstrb = 4'h0; av3 = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests += 4;
        if (i3.ready !== 1'b0)  begin fails++; $display("FAIL rmw_ready3: got %b want 0", i3.ready); end
        if (i3.rvalid !== 1'b0) begin fails++; $display("FAIL rmw_rvalid3: got %b want 0", i3.rvalid); end
        if (i3.rdata !== 32'h0) begin fails++; $display("FAIL rmw_rdata3: got %h want 0", i3.rdata); end
        if (i0.ready !== 1'b1)  begin fails++; $display("FAIL rmw_ready0: got %b want 1", i0.ready); end
        @(negedge clk);
        rst = 1'b0;
        // Counting restarts from IDLE; memory survives reset.
        do_req(1, 32'h40, 32'h0, 4'h0, 3, 32'h12345678, "rmw_rd");
        idle(2);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_back_to_back();
        test_alias();
        test_wait3();
        test_abort();
        test_reset_mid_wait();
        idle(3);
        tests++;
        if (q0.size() != 0 || q3.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: pending reads q0=%0d q3=%0d want 0 0", q0.size(), q3.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
